// File: rtl/pc_branch_unit_if.sv
// Bundle of the fetch-control, table-write and status signals of the
// program counter / branch-target unit. The master side (fetch control)
// drives the requests; the slave side (the unit) returns pc, fault and the
// per-entry valid bits.
interface pc_branch_unit_if #(
  parameter int D = 10,
  parameter int A = 4
);
  logic             stall;
  logic             br_en;
  logic [A-1:0]     br_addr;
  logic             wr_en;
  logic [A-1:0]     wr_addr;
  logic [D-1:0]     wr_target;
  logic             wr_rel;
  logic [D-1:0]     pc;
  logic             fault;
  logic [2**A-1:0]  entry_valid;

  modport master (
    output stall, br_en, br_addr, wr_en, wr_addr, wr_target, wr_rel,
    input  pc, fault, entry_valid
  );

  modport slave (
    input  stall, br_en, br_addr, wr_en, wr_addr, wr_target, wr_rel,
    output pc, fault, entry_valid
  );
endinterface

// File: rtl/pc_branch_unit.sv
// Fetch program counter with a run-time programmable branch-target table.
// Each entry holds a D-bit value plus a mode bit: absolute entries give the
// jump target directly, relative entries give a two's-complement offset that
// is added to the current pc. Branching through an entry that was never
// written since reset increments the pc and raises a one-cycle fault.
module pc_branch_unit #(
  parameter int           D        = 10,
  parameter int           A        = 4,
  parameter logic [D-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  pc_branch_unit_if.slave bus
);
  localparam int           N   = 2**A;
  localparam logic [D-1:0] ONE = {{(D-1){1'b0}}, 1'b1};

  // Target/mode storage carries no reset; only the valid bits do.
  logic [D-1:0] target_mem [N];
  logic         rel_mem    [N];
  logic [N-1:0] valid_reg;
  logic [N-1:0] wr_onehot;

  logic [D-1:0] pc_reg,    pc_next;
  logic         fault_reg, fault_next;

  logic [D-1:0] sel_target;
  logic         sel_rel;
  logic         sel_valid;

  // One-hot decode of the write index, one bit per table entry.
  for (genvar gi = 0; gi < N; gi++) begin : g_wr_dec
    assign wr_onehot[gi] = bus.wr_en && (bus.wr_addr == A'(gi));
  end

  // Table write; suppressed while reset is asserted so a write in progress
  // during reset is discarded.
  always_ff @(posedge clk) begin
    if (bus.wr_en && reset_n) begin
      target_mem[bus.wr_addr] <= bus.wr_target;
      rel_mem[bus.wr_addr]    <= bus.wr_rel;
    end
  end

  // Lookup reads the pre-write contents; a same-cycle write lands at the edge.
  assign sel_target = target_mem[bus.br_addr];
  assign sel_rel    = rel_mem[bus.br_addr];
  assign sel_valid  = valid_reg[bus.br_addr];

  // Next-pc selection in priority order: stall, valid branch, invalid
  // branch (fault), sequential increment.
  always_comb begin
    pc_next    = pc_reg + ONE;
    fault_next = 1'b0;
    if (bus.stall) begin
      pc_next = pc_reg;
    end else if (bus.br_en) begin
      if (!sel_valid) begin
        fault_next = 1'b1;
      end else if (sel_rel) begin
        pc_next = pc_reg + sel_target;
      end else begin
        pc_next = sel_target;
      end
    end
  end

  // PC, fault and valid-bit state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_reg    <= RESET_PC;
      fault_reg <= 1'b0;
      valid_reg <= '0;
    end else begin
      pc_reg    <= pc_next;
      fault_reg <= fault_next;
      valid_reg <= valid_reg | wr_onehot;
    end
  end

  assign bus.pc          = pc_reg;
  assign bus.fault       = fault_reg;
  assign bus.entry_valid = valid_reg;

  // A live lookup must use a known index.
  assert property (@(posedge clk) disable iff (!reset_n)
                   (bus.br_en && !bus.stall) |-> !$isunknown(bus.br_addr))
    else $error("pc_branch_unit: br_addr unknown during branch lookup");

endmodule

// File: tb/tb_pc_branch_unit.sv
// Bench for pc_branch_unit: directed walk through the table features with
// literal expectations, then randomized traffic, all checked every cycle
// against a behavioural model of the table and pc.
module tb_pc_branch_unit;
  localparam int D = 10;
  localparam int A = 4;
  localparam int N = 16;
  localparam int MOD = 1024;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  pc_branch_unit_if #(.D(D), .A(A)) bus ();

  pc_branch_unit #(.D(D), .A(A), .RESET_PC('0)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // behavioural model state
  int m_pc = 0;
  int m_fault = 0;
  int m_tgt [N];
  int m_rel [N];
  bit m_valid [N];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_valid_vec();
    int v = 0;
    for (int i = 0; i < N; i++) if (m_valid[i]) v = v | (1 << i);
    return v;
  endfunction

  task automatic model_reset();
    m_pc = 0;
    m_fault = 0;
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".pc"}, int'(bus.pc), m_pc);
    chk({tag, ".fault"}, int'(bus.fault), m_fault);
    chk({tag, ".valid"}, int'(bus.entry_valid), model_valid_vec());
  endtask

  // Model step at each edge (or on reset), then compare just after.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_reset();
    end else begin
      int ba;
      ba = int'(bus.br_addr);
      if (bus.stall) begin
        m_fault = 0;
      end else if (bus.br_en && m_valid[ba]) begin
        m_pc = m_rel[ba] ? (m_pc + m_tgt[ba]) % MOD : m_tgt[ba];
        m_fault = 0;
      end else begin
        m_pc = (m_pc + 1) % MOD;
        m_fault = bus.br_en ? 1 : 0;
      end
      if (bus.wr_en) begin
        m_tgt[int'(bus.wr_addr)]   = int'(bus.wr_target);
        m_rel[int'(bus.wr_addr)]   = int'(bus.wr_rel);
        m_valid[int'(bus.wr_addr)] = 1'b1;
      end
    end
    #1;
    compare_all("model");
  end

  // Drive one cycle of inputs (called at a falling edge) and wait for the
  // following falling edge, so the resulting pc is visible on return.
  task automatic cyc(input bit st, input bit be, input int ba,
                     input bit we, input int wa, input int wt, input bit wr);
    bus.stall     = st;
    bus.br_en     = be;
    bus.br_addr   = A'(ba);
    bus.wr_en     = we;
    bus.wr_addr   = A'(wa);
    bus.wr_target = D'(wt);
    bus.wr_rel    = wr;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.stall = 0; bus.br_en = 0; bus.br_addr = '0; bus.wr_en = 0;
    bus.wr_addr = '0; bus.wr_target = '0; bus.wr_rel = 0;
    @(negedge clk);
    idle(); idle();
    chk("reset.pc", int'(bus.pc), 0);
    chk("reset.valid", int'(bus.entry_valid), 0);
    reset_n = 1'b1;
    idle(); chk("inc1", int'(bus.pc), 1);
    idle(); chk("inc2", int'(bus.pc), 2);
    idle(); chk("inc3", int'(bus.pc), 3);

    // force pc to 1023, then wrap to 0
    cyc(0, 0, 0, 1, 0, 10'h3FF, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);     chk("force_max", int'(bus.pc), 10'h3FF);
    idle();                       chk("wrap_zero", int'(bus.pc), 0);

    // absolute branch
    cyc(0, 0, 0, 1, 3, 10'h123, 0);
    cyc(0, 1, 3, 0, 0, 0, 0);     chk("abs.pc", int'(bus.pc), 10'h123);
    chk("abs.fault", int'(bus.fault), 0);

    // relative wrap below zero: pc=4, offset -5
    cyc(0, 0, 0, 1, 4, 4, 0);
    cyc(0, 1, 4, 1, 5, 10'h3FB, 1); chk("set_pc4", int'(bus.pc), 4);
    cyc(0, 1, 5, 0, 0, 0, 0);     chk("rel_neg_wrap", int'(bus.pc), 10'h3FF);

    // relative wrap above top: pc=0x3F0, offset +20
    cyc(0, 0, 0, 1, 8, 10'h3F0, 0);
    cyc(0, 1, 8, 1, 6, 10'h014, 1); chk("set_pc3f0", int'(bus.pc), 10'h3F0);
    cyc(0, 1, 6, 0, 0, 0, 0);     chk("rel_pos_wrap", int'(bus.pc), 10'h004);

    // offset -1 decrements, offset 0 self-loops
    cyc(0, 0, 0, 1, 7, 10'h3FF, 1);  // pc 5
    cyc(0, 1, 7, 0, 0, 0, 0);     chk("rel_minus1", int'(bus.pc), 4);
    cyc(0, 0, 0, 1, 10, 0, 1);       // pc 5
    cyc(0, 1, 10, 0, 0, 0, 0);    chk("rel_zero", int'(bus.pc), 5);

    // branch through unwritten entry 9
    cyc(0, 1, 9, 0, 0, 0, 0);     chk("inv.pc", int'(bus.pc), 6);
    chk("inv.fault_hi", int'(bus.fault), 1);
    idle();                       chk("inv.fault_lo", int'(bus.fault), 0);
    chk("inv.pc2", int'(bus.pc), 7);

    // read-during-write on entry 2
    cyc(0, 0, 0, 1, 2, 10'h050, 0);  // pc 8
    cyc(0, 1, 2, 1, 2, 10'h0A0, 0); chk("rdw.old", int'(bus.pc), 10'h050);
    cyc(0, 1, 2, 0, 0, 0, 0);     chk("rdw.new", int'(bus.pc), 10'h0A0);

    // stall with a pending branch and a write to entry 1
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 3, 1, 1, 10'h111, 0);
      chk("stall.pc", int'(bus.pc), 10'h0A0);
      chk("stall.fault", int'(bus.fault), 0);
    end
    chk("stall.valid1", int'(bus.entry_valid[1]), 1);
    idle();                       chk("unstall.pc", int'(bus.pc), 10'h0A1);

    // asynchronous reset mid-cycle
    #2 reset_n = 1'b0;
    #1;
    chk("async.pc", int'(bus.pc), 0);
    chk("async.valid", int'(bus.entry_valid), 0);
    @(negedge clk);
    reset_n = 1'b1;
    idle();                       chk("post_reset.pc", int'(bus.pc), 1);

    // randomized traffic, model checks every cycle
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(3) == 0), ($urandom_range(1) == 1),
          int'($urandom_range(N - 1)), ($urandom_range(9) < 4),
          int'($urandom_range(N - 1)), int'($urandom_range(MOD - 1)),
          ($urandom_range(1) == 1));
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Program counter combined with a runtime-programmable branch-target table.
- Replaces the fixed 16-entry constant target table used by the fetch stage.
- Each table entry is writable at run time and carries a mode bit:
  - absolute: the stored value is the jump target;
  - relative: the stored value is a two's-complement offset added to the current PC.
- Holds the fetch PC. Handles sequential increment, stall, lookup-driven branching, and faults on unprogrammed entries.

Parameters:
- D, 10: PC and target width in bits. All PC arithmetic is modulo 2**D.
- A, 4: table index width. Table depth is 2**A.
- RESET_PC, 0: PC value loaded on reset (D bits).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC and suppress branch/fault for this cycle.
- br_en  in  1  take branch through table entry br_addr this cycle.
- br_addr  in  A  table index used for the branch.
- wr_en  in  1  write one table entry this cycle.
- wr_addr  in  A  index of the entry to write.
- wr_target  in  D  absolute target or two's-complement offset to store.
- wr_rel  in  1  mode bit to store: 1 = relative, 0 = absolute.
- pc  out  D  current PC (registered).
- fault  out  1  one-cycle pulse: a branch used an unprogrammed entry.
- entry_valid  out  2**A  per-entry valid bits (registered), for debug/verification.

Behaviour:
- Reset (reset_n low, asynchronous, effective immediately; holds for as long as asserted):
  - pc = RESET_PC, fault = 0, all valid bits = 0.
  - Target and mode storage is not reset; contents are don't-care until written.
  - Reset asserted mid-operation discards any write or branch in progress that cycle.
- Table write:
  - On the clock edge with wr_en=1: entry[wr_addr] takes {wr_rel, wr_target} and its valid bit is set.
  - Writes are accepted regardless of stall and br_en.
  - There is no invalidate other than reset.
- PC update, evaluated at each rising edge when reset_n is high, in this priority order:
  1. stall=1: pc holds; fault <= 0; br_en is ignored.
  2. br_en=1 and entry[br_addr] valid, absolute mode: pc <= target.
  3. br_en=1 and entry valid, relative mode: pc <= (pc + target) mod 2**D. The offset is D-bit two's complement, and the D-bit add discards the carry.
  4. br_en=1 and entry invalid: pc <= (pc + 1) mod 2**D; fault <= 1 for exactly one cycle.
  5. Otherwise: pc <= (pc + 1) mod 2**D; fault <= 0.
- Read-during-write: a branch that reads the entry being written in the same cycle uses the pre-write contents and valid bit. The new value is visible from the next cycle.
- Latency:
  - A branch decision presented in cycle N appears on pc after the edge ending cycle N (1 cycle).
  - fault is aligned with that same pc update.
- Wrap-around:
  - Increment from 2**D-1 yields 0.
  - A relative target wraps modulo 2**D in either direction.
  - An offset of 0 (relative) is a self-loop.
- Outputs are driven only from registers; there is no combinational path from any input to pc or fault.
- A lookup whose br_addr is X is a simulation assertion failure when br_en=1 and stall=0.

Test Plan:
- Reset and increment (D=10): release reset_n, idle 3 cycles -> pc 0,1,2,3. Force pc to 1023 via an absolute entry, then idle -> next pc = 0. Assert reset_n low mid-cycle -> pc = 0 immediately and all entry_valid bits = 0.
- Absolute branch: write entry 3 = {abs, 0x123}; next cycle br_en=1, br_addr=3 -> pc = 0x123 after one edge; fault stays 0.
- Relative branch wrap:
  - With pc = 4, entry 5 = {rel, 0x3FB (-5)}: branch -> pc = 0x3FF.
  - From pc = 0x3F0, entry 6 = {rel, 0x014 (+20)}: branch -> pc = 0x004.
  - Entry 7 = {rel, 0x3FF (-1)}: branch -> pc decrements by 1.
  - Entry with offset 0: branch -> pc unchanged.
- Invalid entry after reset: br_en=1, br_addr=9 with entry 9 unwritten -> pc increments by 1; fault high for exactly one cycle, then low.
- Read-during-write: entry 2 = {abs, 0x050}. In the same cycle write entry 2 = {abs, 0x0A0} and branch on 2 -> pc = 0x050. Branch on 2 again the next cycle -> pc = 0x0A0.
- Stall: stall=1 for 3 cycles with br_en=1 on a valid entry plus a write to entry 1 -> pc constant, fault 0, and entry_valid[1] set. Drop stall with br_en=0 -> pc increments once.
